// File: rtl/mips_pkg.sv
// Shared encodings for the instruction-fetch stage: jump selects, FSM states, field slices.
package mips_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned JUMP_W    = 2;

    localparam logic [JUMP_W-1:0] JUMP_SEQ = 2'b00;
    localparam logic [JUMP_W-1:0] JUMP_J   = 2'b01;
    localparam logic [JUMP_W-1:0] JUMP_JR  = 2'b10;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection; jump takes priority over a branch.
module next_pc
    import mips_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0]       pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               pcsrc,
    input  logic [JUMP_W-1:0]  jump,
    input  logic [n-1:0]       jr_target,
    output logic [n-1:0]       npc
);

    logic [n-1:0] seq;
    logic [n-1:0] br_off;
    logic         unused_bits;

    assign seq    = pc + n'(4);
    assign br_off = {{(n-18){instr[15]}}, instr[15:0], 2'b00};

    // Opcode field and low register bits play no part in target formation.
    assign unused_bits = ^{instr[31:26], jr_target[1:0]};

    always_comb begin
        npc = seq;
        case (jump)
            JUMP_J:   npc = {seq[n-1:28], instr[25:0], 2'b00};
            JUMP_JR:  npc = {jr_target[n-1:2], 2'b00};
            JUMP_SEQ: if (pcsrc) npc = seq + br_off;
            default:  npc = seq;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/rvalid, holds the word until acked.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned  n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [n-1:0]       imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic               instr_valid,
    input  logic               instr_ack,
    input  logic               pcsrc,
    input  logic [JUMP_W-1:0]  jump,
    input  logic [n-1:0]       jr_target,
    output logic [n-1:0]       pc,
    output logic [n-1:0]       pcplus4
);

    fetch_state_t       state, state_d;
    logic [n-1:0]       pc_q, pc_d, npc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;

    next_pc #(.n(n)) u_next_pc (
        .pc        (pc_q),
        .instr     (instr_q),
        .pcsrc     (pcsrc),
        .jump      (jump),
        .jr_target (jr_target),
        .npc       (npc)
    );

    // State and datapath registers; reset also discards any in-flight response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    // rvalid only matters in FETCH and ack only in HOLD, so they never collide.
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    pc_d    = npc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d   = (state_d == FETCH);
        valid_d = (state_d == HOLD);
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[OP_MSB:OP_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pcplus4     = pc_q + n'(4);

endmodule
